// File: rtl/ex_muldiv.sv
// ex_muldiv: execute-stage RV32M multiply/divide unit plus the EX/MEM pipeline
// register. Non-M instructions pass straight through in one edge; M instructions
// hold the front of the pipeline for 33 cycles while a 32-step iterative engine
// runs, and MEM sees bubbles until the corrected result is loaded.
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [1:0]      wb_ctl,
    input  logic            branch_in,
    input  logic            memread_in,
    input  logic            memwrite_in,
    input  logic            md_en,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic            zero_in,
    input  logic [XLEN-1:0] rdata2_in,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            ex_stall,
    output logic [1:0]      wb_ctlout,
    output logic            branch,
    output logic            memread,
    output logic            memwrite,
    output logic            zero,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] rdata2out,
    output logic [4:0]      five_bit_muxout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [1:0]      wb;
        logic            branch;
        logic            memread;
        logic            memwrite;
        logic            zero;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] rdata2;
        logic [4:0]      rd;
    } ex_mem_t;

    // Funct3 encodings that matter to the datapath.
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    state_e            state_q;
    logic [5:0]        cnt_q;
    logic [2*XLEN-1:0] acc_q;       // mul: {hi, multiplier/lo}; div: {remainder, dividend/quotient}
    logic [2*XLEN-1:0] acc_d;
    logic [XLEN-1:0]   mcand_q;     // multiplicand magnitude or divisor magnitude
    logic [XLEN-1:0]   a_raw_q;     // original rs1, returned by REM/REMU on divide-by-zero
    logic              neg_q;       // product / quotient must be negated
    logic              rneg_q;      // remainder must be negated (dividend was negative)
    logic              div0_q;
    logic [2:0]        op_q;
    logic [1:0]        lwb_q;
    logic [4:0]        lrd_q;
    ex_mem_t           exmem_q;
    ex_mem_t           exmem_d;

    logic              a_sgn, b_sgn, sa, sb;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, md_result;

    // Stall the front end while an M op is being accepted or is iterating.
    always_comb begin
        ex_stall = reset && !flush &&
                   ((state_q == S_BUSY) || (state_q == S_IDLE && id_valid && md_en));
    end

    // Operand preparation: signedness per funct3, then magnitudes for the unsigned engine.
    always_comb begin
        a_sgn = (md_op == OP_MULH) || (md_op == OP_MULHSU) || (md_op == OP_DIV) || (md_op == OP_REM);
        b_sgn = (md_op == OP_MULH) || (md_op == OP_DIV) || (md_op == OP_REM);
        sa    = a_sgn && src_a[XLEN-1];
        sb    = b_sgn && src_b[XLEN-1];
        mag_a = sa ? (~src_a + 1'b1) : src_a;
        mag_b = sb ? (~src_b + 1'b1) : src_b;
    end

    // One engine step: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a value on all
        // paths (defaults first) so no latch is inferred.
        acc_d     = acc_q;
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        if (op_q[2]) begin
            if (div_shift >= {1'b0, mcand_q}) begin
                acc_d = {div_shift[XLEN-1:0] - mcand_q, acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // Sign correction and special-case selection of the finished M result.
    always_comb begin
        prod_fix  = neg_q  ? (~acc_q + 1'b1) : acc_q;
        quo_fix   = neg_q  ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_fix   = rneg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
        md_result = '0;
        case (op_q)
            OP_MUL:       md_result = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: md_result = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:   md_result = div0_q ? '1 : quo_fix;
            default:      md_result = div0_q ? a_raw_q : rem_fix;
        endcase
    end

    // Next EX/MEM contents: pass-through, M result, or a bubble.
    always_comb begin
        exmem_d = '0;
        if (!flush) begin
            if (state_q == S_IDLE && id_valid && !md_en) begin
                exmem_d.wb       = wb_ctl;
                exmem_d.branch   = branch_in;
                exmem_d.memread  = memread_in;
                exmem_d.memwrite = memwrite_in;
                exmem_d.zero     = zero_in;
                exmem_d.result   = alu_result_in;
                exmem_d.rdata2   = rdata2_in;
                exmem_d.rd       = rd_in;
            end else if (state_q == S_DONE) begin
                exmem_d.wb     = lwb_q;
                exmem_d.zero   = (md_result == '0);
                exmem_d.result = md_result;
                exmem_d.rd     = lrd_q;
            end
        end
    end

    // FSM, iteration engine and EX/MEM register; reset beats flush beats everything else.
    always_ff @(posedge clock) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            a_raw_q <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
            op_q    <= '0;
            lwb_q   <= '0;
            lrd_q   <= '0;
            exmem_q <= '0;
        end else begin
            exmem_q <= exmem_d;
            if (flush) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (id_valid && md_en) begin
                            acc_q   <= {{XLEN{1'b0}}, mag_a};
                            mcand_q <= mag_b;
                            a_raw_q <= src_a;
                            neg_q   <= sa ^ sb;
                            rneg_q  <= sa;
                            div0_q  <= (src_b == '0);
                            op_q    <= md_op;
                            lwb_q   <= wb_ctl;
                            lrd_q   <= rd_in;
                            cnt_q   <= '0;
                            state_q <= S_BUSY;
                        end
                    end
                    S_BUSY: begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'd31) begin
                            state_q <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign wb_ctlout       = exmem_q.wb;
    assign branch          = exmem_q.branch;
    assign memread         = exmem_q.memread;
    assign memwrite        = exmem_q.memwrite;
    assign zero            = exmem_q.zero;
    assign alu_result      = exmem_q.result;
    assign rdata2out       = exmem_q.rdata2;
    assign five_bit_muxout = exmem_q.rd;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: reset, pass-through, multiply/divide results,
// divide special cases, stall length, flush and reset during an operation.
module tb_ex_muldiv;

    logic        clock;
    logic        reset;
    logic        id_valid;
    logic [1:0]  wb_ctl;
    logic        branch_in, memread_in, memwrite_in;
    logic        md_en;
    logic [2:0]  md_op;
    logic [31:0] src_a, src_b, alu_result_in, rdata2_in;
    logic        zero_in;
    logic [4:0]  rd_in;
    logic        flush;
    logic        ex_stall;
    logic [1:0]  wb_ctlout;
    logic        branch, memread, memwrite, zero;
    logic [31:0] alu_result, rdata2out;
    logic [4:0]  five_bit_muxout;

    int checks = 0;
    int errors = 0;

    ex_muldiv #(.XLEN(32)) dut (
        .clock           (clock),
        .reset           (reset),
        .id_valid        (id_valid),
        .wb_ctl          (wb_ctl),
        .branch_in       (branch_in),
        .memread_in      (memread_in),
        .memwrite_in     (memwrite_in),
        .md_en           (md_en),
        .md_op           (md_op),
        .src_a           (src_a),
        .src_b           (src_b),
        .alu_result_in   (alu_result_in),
        .zero_in         (zero_in),
        .rdata2_in       (rdata2_in),
        .rd_in           (rd_in),
        .flush           (flush),
        .ex_stall        (ex_stall),
        .wb_ctlout       (wb_ctlout),
        .branch          (branch),
        .memread         (memread),
        .memwrite        (memwrite),
        .zero            (zero),
        .alu_result      (alu_result),
        .rdata2out       (rdata2out),
        .five_bit_muxout (five_bit_muxout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one M op from just after an edge, count stall cycles and bubbles,
    // then check the result that appears on the outputs in cycle 34.
    task automatic do_m(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
        int stalls = 0;
        int bad_bubbles = 0;
        id_valid = 1'b1; md_en = 1'b1; md_op = op; src_a = a; src_b = b;
        wb_ctl = 2'b10; rd_in = 5'd7; alu_result_in = 32'hDEAD_BEEF;
        memread_in = 1'b1; branch_in = 1'b1; memwrite_in = 1'b1; zero_in = 1'b1;
        #1;
        while (ex_stall && stalls < 40) begin
            stalls++;
            @(posedge clock); #1;
            if (wb_ctlout !== 2'b00 || alu_result !== 32'h0 || memread !== 1'b0) bad_bubbles++;
        end
        check({tag, "_stalls"}, stalls, 33);
        check({tag, "_bubbles"}, bad_bubbles, 0);
        @(posedge clock); #1;
        id_valid = 1'b0; md_en = 1'b0;
        memread_in = 1'b0; branch_in = 1'b0; memwrite_in = 1'b0; zero_in = 1'b0;
        check({tag, "_result"}, alu_result, exp);
        check({tag, "_zero"}, zero, (exp == 32'h0));
        check({tag, "_wb_rd"}, {wb_ctlout, five_bit_muxout}, {2'b10, 5'd7});
        check({tag, "_memctl"}, {branch, memread, memwrite}, 3'b000);
    endtask

    initial begin
        int viol;
        int n;
        reset = 1'b0; id_valid = 1'b1; md_en = 1'b1; md_op = 3'd0;
        wb_ctl = 2'b11; branch_in = 1'b1; memread_in = 1'b1; memwrite_in = 1'b1;
        src_a = 32'd5; src_b = 32'd6; alu_result_in = 32'hFFFF; zero_in = 1'b1;
        rdata2_in = 32'h77; rd_in = 5'd9; flush = 1'b0;

        // Reset held for two edges with an M instruction presented.
        #2;
        check("stall_in_reset", ex_stall, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        check("rst_wb", wb_ctlout, 2'b00);
        check("rst_result", alu_result, 32'h0);
        check("rst_rd_data", {five_bit_muxout, rdata2out}, 37'h0);
        check("rst_flags", {branch, memread, memwrite, zero}, 4'h0);
        check("rst_stall", ex_stall, 1'b0);

        // Release reset with a non-M op: one-edge pass-through.
        reset = 1'b1; md_en = 1'b0; alu_result_in = 32'h1234; rd_in = 5'd5;
        wb_ctl = 2'b10; rdata2_in = 32'hCAFE; zero_in = 1'b0;
        branch_in = 1'b0; memread_in = 1'b1; memwrite_in = 1'b0;
        #1;
        check("nonm_stall", ex_stall, 1'b0);
        @(posedge clock); #1;
        check("nonm_result", alu_result, 32'h1234);
        check("nonm_rd", five_bit_muxout, 5'd5);
        check("nonm_wb", wb_ctlout, 2'b10);
        check("nonm_store", rdata2out, 32'hCAFE);
        check("nonm_ctl", {branch, memread, memwrite, zero}, 4'b0100);
        id_valid = 1'b0;
        @(posedge clock); #1;
        check("idle_bubble", {wb_ctlout, memread}, 3'b000);

        // Multiply and divide vectors, issued back to back.
        do_m(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
        do_m(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh");
        do_m(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
        do_m(3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, "mulhsu");
        do_m(3'd5, 32'd100,       32'd0,         32'hFFFF_FFFF, "divu_by0");
        do_m(3'd7, 32'd100,       32'd0,         32'd100,       "remu_by0");
        do_m(3'd4, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, "div_by0");
        do_m(3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, "rem_by0");
        do_m(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        do_m(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         "rem_ovf");
        do_m(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_neg");
        do_m(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_neg");
        do_m(3'd5, 32'd1000,      32'd7,         32'd142,       "divu");

        // Flush in cycle 10 of a DIV.
        id_valid = 1'b1; md_en = 1'b1; md_op = 3'd4; src_a = 32'd50; src_b = 32'd5;
        wb_ctl = 2'b10; rd_in = 5'd4;
        repeat (10) @(posedge clock);
        #1;
        check("flush_busy_stall", ex_stall, 1'b1);
        flush = 1'b1;
        #1;
        check("flush_forces_stall0", ex_stall, 1'b0);
        @(posedge clock); #1;
        flush = 1'b0; id_valid = 1'b0; md_en = 1'b0;
        check("flush_bubble", {wb_ctlout, alu_result}, 34'h0);
        #1;
        check("flush_c11_stall", ex_stall, 1'b0);
        id_valid = 1'b1; alu_result_in = 32'h55; rd_in = 5'd3; wb_ctl = 2'b11; memread_in = 1'b0;
        @(posedge clock); #1;
        check("after_flush_nonm", {alu_result, five_bit_muxout, wb_ctlout}, {32'h55, 5'd3, 2'b11});
        id_valid = 1'b0;

        // Flush together with an M issue in IDLE: no stall, instruction dropped.
        @(posedge clock); #1;
        id_valid = 1'b1; md_en = 1'b1; md_op = 3'd0; src_a = 32'd3; src_b = 32'd3; flush = 1'b1;
        #1;
        check("flush_issue_stall", ex_stall, 1'b0);
        @(posedge clock); #1;
        flush = 1'b0; id_valid = 1'b1; md_en = 1'b0; alu_result_in = 32'h66; rd_in = 5'd2;
        check("flush_issue_bubble", wb_ctlout, 2'b00);
        #1;
        check("flush_issue_idle_stall", ex_stall, 1'b0);
        @(posedge clock); #1;
        check("flush_issue_then_nonm", alu_result, 32'h66);

        // Flush in DONE discards the result.
        md_en = 1'b1; md_op = 3'd0; src_a = 32'd9; src_b = 32'd9; rd_in = 5'd8;
        n = 0;
        #1;
        while (ex_stall && n < 40) begin
            n++;
            @(posedge clock); #1;
        end
        check("done_flush_stalls", n, 33);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0; id_valid = 1'b0; md_en = 1'b0;
        check("done_flush_bubble", {wb_ctlout, alu_result, five_bit_muxout}, 39'h0);

        // Reset in cycle 20 of a MUL: outputs cleared and no result ever emitted.
        @(posedge clock); #1;
        id_valid = 1'b1; md_en = 1'b1; md_op = 3'd0; src_a = 32'd6; src_b = 32'd7;
        wb_ctl = 2'b10; rd_in = 5'd1;
        repeat (20) @(posedge clock);
        #1;
        reset = 1'b0; id_valid = 1'b0; md_en = 1'b0;
        #1;
        check("midop_rst_stall", ex_stall, 1'b0);
        @(posedge clock); #1;
        check("midop_rst_out", {wb_ctlout, alu_result, five_bit_muxout}, 39'h0);
        reset = 1'b1;
        viol = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (wb_ctlout !== 2'b00 || alu_result !== 32'h0 || ex_stall !== 1'b0) viol++;
        end
        check("midop_no_result", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
